// File: rtl/anneal_accept_unit.sv
// anneal_accept_unit: Metropolis accept/reject stage with a geometric cooling schedule.
// Each decision compares a random word against temp >> delta_e; every SWEEP_LEN decisions the temperature cools.
module anneal_accept_unit #(
    parameter int          DE_W        = 8,
    parameter logic [15:0] T_INIT      = 16'h8000,
    parameter logic [15:0] T_MIN       = 16'h0100,
    parameter int          SWEEP_LEN   = 64,
    parameter int          DECAY_SHIFT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     rand_in,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DE_W-1:0] delta_e,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            accept,
    output logic [15:0]     temp_out,
    output logic [15:0]     sweep_cnt,
    output logic            done
);
    localparam int CW = $clog2(SWEEP_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, RESP, DONE} state_t;
    state_t        state_q, state_d;
    logic [15:0]   temp_q, temp_d, sweep_q, sweep_d, thr, next_t;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d, req_ready_q;
    logic          de_pos, de_big, decide;
    always_comb begin
        de_pos   = !delta_e[DE_W-1] && |delta_e;
        de_big   = !delta_e[DE_W-1] && (delta_e[DE_W-2:0] >= (DE_W-1)'(16));
        thr      = de_big ? '0 : temp_q >> delta_e[3:0];
        decide   = !de_pos || (rand_in < thr);
        next_t   = temp_q - (temp_q >> DECAY_SHIFT);
        state_d  = state_q;
        temp_d   = temp_q;
        sweep_d  = sweep_q;
        cnt_d    = cnt_q;
        accept_d = accept_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = RUN;
                temp_d  = T_INIT;
                sweep_d = '0;
                cnt_d   = '0;
            end
            RUN: if (req_valid) begin
                state_d  = RESP;
                accept_d = decide;
            end
            RESP: if (resp_ready) begin
                state_d = RUN;
                cnt_d   = cnt_q + CW'(1);
                // End of a sweep: cool, and stop once the floor is hit or cooling stalls
                if (cnt_q == CW'(SWEEP_LEN - 1)) begin
                    cnt_d   = '0;
                    sweep_d = (&sweep_q) ? sweep_q : sweep_q + 16'd1;
                    temp_d  = (next_t <= T_MIN || next_t == temp_q) ? T_MIN : next_t;
                    state_d = (next_t <= T_MIN || next_t == temp_q) ? DONE : RUN;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            temp_q      <= '0;
            sweep_q     <= '0;
            cnt_q       <= '0;
            accept_q    <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            temp_q      <= temp_d;
            sweep_q     <= sweep_d;
            cnt_q       <= cnt_d;
            accept_q    <= accept_d;
            req_ready_q <= (state_d == RUN);
        end
    end
    assign req_ready  = req_ready_q;
    assign resp_valid = (state_q == RESP);
    assign accept     = accept_q;
    assign temp_out   = temp_q;
    assign sweep_cnt  = sweep_q;
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_anneal_accept_unit.sv
// tb_anneal_accept_unit: directed and randomized checks of anneal_accept_unit against an arithmetic model.
module tb_anneal_accept_unit;
    logic              clk = 1'b0;
    logic              rst_n, start, req_valid, resp_ready;
    logic [15:0]       rand_in;
    logic signed [7:0] delta_e;
    logic              req_ready, resp_valid, accept, done;
    logic [15:0]       temp_out, sweep_cnt;
    int  n_vec = 0, n_miss = 0;
    int  m_temp = 0, m_sweep = 0, m_cnt = 0;
    bit  m_done = 0;

    anneal_accept_unit #(.DE_W(8), .T_INIT(16'h8000), .T_MIN(16'h0100),
                         .SWEEP_LEN(4), .DECAY_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rand_in(rand_in),
        .req_valid(req_valid), .req_ready(req_ready), .delta_e(delta_e),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .accept(accept),
        .temp_out(temp_out), .sweep_cnt(sweep_cnt), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_accept(input int de, input int r, input int t);
        int thr;
        if (de <= 0) return 1'b1;
        thr = (de >= 16) ? 0 : t / (1 << de);
        return r < thr;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_temp == 0 || m_done) begin
            m_temp = 'h8000; m_sweep = 0; m_cnt = 0; m_done = 0;
        end
    endtask

    task automatic do_req(input int de, input int r, input int hold);
        bit exp_a;
        chk("req_ready_before", req_ready, 1);
        exp_a      = exp_accept(de, r, m_temp);
        req_valid  = 1'b1;
        delta_e    = 8'(de);
        rand_in    = 16'(r);
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        rand_in   = 16'($urandom);
        delta_e   = 8'($urandom);
        chk("resp_valid", resp_valid, 1);
        chk("accept", accept, exp_a);
        chk("req_ready_resp", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", resp_valid, 1);
            chk("hold_accept", accept, exp_a);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        m_cnt++;
        if (m_cnt == 4) begin
            int nt;
            m_cnt = 0;
            m_sweep++;
            nt = m_temp - m_temp / 16;
            if (nt <= 'h100 || nt == m_temp) begin
                m_temp = 'h100;
                m_done = 1;
            end else m_temp = nt;
        end
        chk("resp_valid_drop", resp_valid, 0);
        chk("temp_out", temp_out, m_temp);
        chk("sweep_cnt", sweep_cnt, m_sweep);
        chk("done", done, m_done);
        chk("req_ready_after", req_ready, !m_done);
    endtask

    initial begin
        int iter;
        rst_n = 1'b0; start = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        rand_in = '0; delta_e = '0;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_accept", accept, 0);
        chk("rst_done", done, 0);
        chk("rst_temp", temp_out, 0);
        chk("rst_sweep", sweep_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", req_ready, 0);
        pulse_start();
        chk("start_temp", temp_out, 'h8000);
        chk("start_req_ready", req_ready, 1);
        chk("start_done", done, 0);
        do_req(-3, 'hFFFF, 0);
        do_req(2, 'h1FFF, 0);
        do_req(2, 'h2000, 0);
        do_req(16, 0, 0);
        chk("cool_temp", temp_out, 'h7800);
        chk("cool_sweep", sweep_cnt, 1);
        do_req(1, int'($urandom_range(0, 'hFFFF)), 5);
        pulse_start();
        chk("start_ignored_temp", temp_out, m_temp);
        chk("start_ignored_sweep", sweep_cnt, m_sweep);
        req_valid = 1'b1; delta_e = 8'sd3; rand_in = 16'h0;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", resp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_resp_valid", resp_valid, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_temp", temp_out, 0);
        chk("async_done", done, 0);
        m_temp = 0; m_sweep = 0; m_cnt = 0; m_done = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req_ready", req_ready, 0);
        chk("post_rst_sweep", sweep_cnt, 0);
        pulse_start();
        iter = 0;
        while (!m_done && iter < 2000) begin
            do_req(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 'hFFFF)),
                   int'($urandom_range(0, 2)));
            iter++;
        end
        chk("final_done", done, 1);
        chk("final_temp", temp_out, 'h0100);
        chk("final_req_ready", req_ready, 0);
        tick();
        chk("done_held", done, 1);
        pulse_start();
        chk("restart_temp", temp_out, 'h8000);
        chk("restart_done", done, 0);
        chk("restart_sweep", sweep_cnt, 0);
        chk("restart_req_ready", req_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/anneal_accept_unit.md
Name: anneal_accept_unit

Overview:
- Metropolis acceptance stage of the BitSieve digital annealer. It sits directly downstream of the 16-bit LFSR and consumes its `data_out` word as the uniform random source.
- For each proposed spin flip it receives the energy change `delta_e` and returns an accept/reject decision. Acceptance probability is approximated as 2^-delta_e scaled by the current temperature.
- It owns the geometric cooling schedule and flags completion when the temperature floor is reached.

Parameters:
- DE_W, 8, width of signed `delta_e`.
- T_INIT, 16'h8000, temperature loaded on `start`.
- T_MIN, 16'h0100, temperature floor; reaching it ends the anneal.
- SWEEP_LEN, 64, completed decisions per temperature step (≥1).
- DECAY_SHIFT, 4, cooling step is temp −= temp >> DECAY_SHIFT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new anneal from IDLE or DONE.
- rand_in  in  16  random word from the LFSR, new value every clock.
- req_valid  in  1  a proposed flip is present.
- req_ready  out  1  unit can accept a request.
- delta_e  in  DE_W  signed energy change of the proposed flip.
- resp_valid  out  1  decision available.
- resp_ready  in  1  consumer takes the decision.
- accept  out  1  1 = apply flip; valid while `resp_valid` is high.
- temp_out  out  16  current temperature.
- sweep_cnt  out  16  completed temperature steps since `start`.
- done  out  1  anneal finished; level signal.

Behaviour:
- Reset (async, `rst_n` = 0): state = IDLE; `req_ready`, `resp_valid`, `accept`, `done` = 0; `temp_out` = 0; `sweep_cnt` = 0; internal decision counter = 0.
- States and transitions:
  - IDLE: `start` → RUN.
  - RUN: request handshake → RESP.
  - RESP: response handshake → RUN, or → DONE.
  - DONE: `start` → RUN.
- `start` taken in IDLE or DONE: `temp` ← T_INIT, `sweep_cnt` ← 0, decision counter ← 0, `done` ← 0, go RUN.
- `start` is ignored in RUN and RESP.
- `req_ready` = 1 only in RUN (registered, asserted the cycle after entering RUN).
- Request handshake is `req_valid` & `req_ready` at a rising edge; `rand_in` and `delta_e` are sampled at that same edge.
- Decision, computed from the sampled values:
  - `delta_e` ≤ 0 → `accept` = 1.
  - Otherwise shamt = min(`delta_e`, 16); thr = (shamt == 16) ? 0 : `temp` >> shamt; `accept` = (`rand_in` < thr), unsigned compare.
- Latency: request accepted at edge N → `resp_valid` = 1 and `accept` valid after edge N. Maximum throughput is one decision per 2 cycles.
- RESP: `resp_valid` and `accept` are held stable until `resp_ready` = 1. Backpressure of any length is legal.
- On the response handshake, `resp_valid` drops the next cycle and the decision counter increments.
- When the counter reaches SWEEP_LEN:
  - counter ← 0; `sweep_cnt` += 1 (saturates at 16'hFFFF).
  - next = `temp` − (`temp` >> DECAY_SHIFT).
  - If next ≤ T_MIN or next == `temp` (no progress): `temp` ← T_MIN, go DONE, `done` = 1.
  - Else `temp` ← next, go RUN.
- DONE: `req_ready` = 0; `done` held until the next `start` or reset.
- `temp_out` mirrors the `temp` register; it updates on the same edge as the cooling step.
- Reset mid-operation aborts any pending request or response; there is no partial state retention.
- Arithmetic is unsigned 16-bit on `temp`; `delta_e` is two's complement.
- `rand_in` is treated as opaque. The unit never stalls or drives the LFSR.

Test Plan:
- Reset: assert `rst_n` = 0 mid-RESP → `resp_valid` = 0, `req_ready` = 0, `temp_out` = 0, `done` = 0 asynchronously; after release the state is IDLE.
- Favourable flip: `start`, then `delta_e` = −3 with `rand_in` = 16'hFFFF → `resp_valid` one cycle later, `accept` = 1.
- Threshold edge: temp 16'h8000, `delta_e` = 2 (thr = 16'h2000):
  - `rand_in` = 16'h1FFF → `accept` = 1.
  - `rand_in` = 16'h2000 → `accept` = 0.
  - `delta_e` = 16 with `rand_in` = 0 → `accept` = 0.
- Backpressure: hold `resp_ready` = 0 for 5 cycles → `resp_valid` and `accept` stable, `req_ready` = 0; release → next request is accepted only after returning to RUN.
- Cooling: SWEEP_LEN = 4, DECAY_SHIFT = 4; 4 handshaked decisions → `temp_out` 16'h8000 → 16'h7800, `sweep_cnt` = 1.
- Completion: run decisions until temp ≤ T_MIN → `temp_out` = 16'h0100, `done` = 1, `req_ready` = 0; a further `start` pulse → `temp_out` = 16'h8000, `done` = 0.
